// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, DMA is forced after STARVE_LIMIT denials.
// Partial CPU stores run as read (stalled) then write; everything else completes in its grant cycle.
module dm_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CpuReq,
    input  logic        CpuWe,
    input  logic [31:0] CpuAddr,
    input  logic [31:0] CpuWData,
    input  logic [3:0]  CpuBE,
    output logic [31:0] CpuRData,
    output logic        CpuStall,
    input  logic        DmaReq,
    input  logic        DmaWe,
    input  logic [31:0] DmaAddr,
    input  logic [31:0] DmaWData,
    output logic        DmaAck,
    output logic [31:0] DmaRData,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemWrite,
    input  logic [31:0] MemRData
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RMW  = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rmw_addr;
    logic [31:0]   r_rmw_data;

    logic        w_idle;
    logic        w_full_store;
    logic        w_partial;
    logic        w_dma_force;
    logic        w_grant_dma;
    logic        w_grant_cpu;
    logic        w_rmw_start;
    logic [31:0] w_cpu_addr;
    logic [31:0] w_dma_addr;
    logic [31:0] w_merged;
    logic        w_unused;

    assign w_idle       = (r_state == S_IDLE);
    assign w_cpu_addr   = {CpuAddr[31:2], 2'b00};
    assign w_dma_addr   = {DmaAddr[31:2], 2'b00};
    assign w_unused     = ^{CpuAddr[1:0], DmaAddr[1:0]};

    // CpuWe with no byte enables is a load; only 1-3 enabled bytes need the read-modify-write
    assign w_full_store = CpuWe && (CpuBE == 4'b1111);
    assign w_partial    = CpuWe && (CpuBE != 4'b1111) && (CpuBE != 4'b0000);

    assign w_dma_force  = DmaReq && (r_cnt == CNT_MAX);
    assign w_grant_dma  = w_idle && DmaReq && (w_dma_force || !CpuReq);
    assign w_grant_cpu  = w_idle && CpuReq && !w_dma_force;
    assign w_rmw_start  = w_grant_cpu && w_partial;

    always_comb begin
        w_merged = MemRData;
        for (int b = 0; b < 4; b++) begin
            if (CpuBE[b]) begin
                w_merged[8*b +: 8] = CpuWData[8*b +: 8];
            end
        end
    end

    always_comb begin
        MemAddr  = 32'd0;
        MemWData = 32'd0;
        MemWrite = 1'b0;
        CpuRData = 32'd0;
        CpuStall = 1'b0;
        DmaAck   = 1'b0;
        DmaRData = 32'd0;
        if (!Reset) begin
            if (r_state == S_RMW) begin
                MemAddr  = r_rmw_addr;
                MemWData = r_rmw_data;
                MemWrite = 1'b1;
            end else if (w_grant_dma) begin
                MemAddr  = w_dma_addr;
                MemWData = DmaWData;
                MemWrite = DmaWe;
                DmaAck   = 1'b1;
                DmaRData = MemRData;
                CpuStall = CpuReq;
            end else if (w_grant_cpu) begin
                MemAddr  = w_cpu_addr;
                MemWData = CpuWData;
                MemWrite = w_full_store;
                CpuRData = MemRData;
                CpuStall = w_partial;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rmw_addr <= 32'd0;
            r_rmw_data <= 32'd0;
        end else begin
            r_state <= w_rmw_start ? S_RMW : S_IDLE;
            if (w_rmw_start) begin
                r_rmw_addr <= w_cpu_addr;
                r_rmw_data <= w_merged;
            end
            // Denied cycles count toward the limit, RMW cycles included
            if (!DmaReq || w_grant_dma) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_dm_arbiter;

    localparam int L = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CpuReq, CpuWe;
    logic [31:0] CpuAddr, CpuWData;
    logic [3:0]  CpuBE;
    logic [31:0] CpuRData;
    logic        CpuStall;
    logic        DmaReq, DmaWe;
    logic [31:0] DmaAddr, DmaWData;
    logic        DmaAck;
    logic [31:0] DmaRData;
    logic [31:0] MemAddr, MemWData;
    logic        MemWrite;
    logic [31:0] MemRData;

    logic        mem_init;
    logic [31:0] dm_mem  [16];
    logic [31:0] ref_mem [16];

    bit          m_rmw;
    logic [31:0] m_rmw_addr, m_rmw_word;
    int          m_wait;
    bit          last_stall, last_ack;
    int          n_vec, n_err;

    dm_arbiter #(.STARVE_LIMIT(L)) dut (
        .Clk(Clk), .Reset(Reset),
        .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuBE(CpuBE), .CpuRData(CpuRData), .CpuStall(CpuStall),
        .DmaReq(DmaReq), .DmaWe(DmaWe), .DmaAddr(DmaAddr), .DmaWData(DmaWData),
        .DmaAck(DmaAck), .DmaRData(DmaRData),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemWrite(MemWrite), .MemRData(MemRData)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] pat(input int i);
        return 32'hA5C3_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Stand-in for the dm block: combinational read, write on the clock edge
    assign MemRData = dm_mem[MemAddr[5:2]];
    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) dm_mem[i] <= pat(i);
        end else if (MemWrite) begin
            dm_mem[MemAddr[5:2]] <= MemWData;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        CpuReq = req; CpuWe = we; CpuAddr = a; CpuWData = d; CpuBE = be;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        DmaReq = req; DmaWe = we; DmaAddr = a; DmaWData = d;
    endtask

    function automatic int sat_wait(input int w);
        return (w < L) ? w + 1 : L;
    endfunction

    // Model: at most one memory transaction per cycle; a pending merged word always wins the next cycle
    task automatic sample();
        logic [31:0] e_addr, e_wdata, e_crd, e_drd, mask;
        logic        e_wr, e_stall, e_ack;
        bit          chk_crd;
        int          ci, di;
        #3;
        e_addr = 0; e_wdata = 0; e_crd = 0; e_drd = 0;
        e_wr = 0; e_stall = 0; e_ack = 0; chk_crd = 1;
        ci = int'(CpuAddr[5:2]);
        di = int'(DmaAddr[5:2]);
        if (Reset) begin
            m_rmw  = 0;
            m_wait = 0;
        end else if (m_rmw) begin
            e_addr = m_rmw_addr; e_wdata = m_rmw_word; e_wr = 1; chk_crd = 0;
            ref_mem[m_rmw_addr[5:2]] = m_rmw_word;
            m_rmw  = 0;
            m_wait = DmaReq ? sat_wait(m_wait) : 0;
        end else if (DmaReq && (m_wait >= L || !CpuReq)) begin
            e_addr = DmaAddr & ~32'h3; e_ack = 1; e_stall = CpuReq;
            e_drd = ref_mem[di]; e_wr = DmaWe; e_wdata = DmaWData;
            if (DmaWe) ref_mem[di] = DmaWData;
            m_wait = 0;
        end else begin
            if (CpuReq) begin
                e_addr = CpuAddr & ~32'h3; e_crd = ref_mem[ci]; e_wdata = CpuWData;
                if (CpuWe && CpuBE == 4'hF) begin
                    e_wr = 1;
                    ref_mem[ci] = CpuWData;
                end else if (CpuWe && CpuBE != 4'h0) begin
                    mask = {{8{CpuBE[3]}}, {8{CpuBE[2]}}, {8{CpuBE[1]}}, {8{CpuBE[0]}}};
                    m_rmw_word = (CpuWData & mask) | (ref_mem[ci] & ~mask);
                    m_rmw_addr = e_addr;
                    m_rmw   = 1;
                    e_stall = 1;
                end
            end
            m_wait = DmaReq ? sat_wait(m_wait) : 0;
        end
        chk("MemAddr", MemAddr, e_addr);
        chk("MemWrite", 32'(MemWrite), 32'(e_wr));
        if (e_wr) chk("MemWData", MemWData, e_wdata);
        chk("CpuStall", 32'(CpuStall), 32'(e_stall));
        chk("DmaAck", 32'(DmaAck), 32'(e_ack));
        chk("DmaRData", DmaRData, e_drd);
        if (chk_crd) chk("CpuRData", CpuRData, e_crd);
        last_stall = e_stall;
        last_ack   = e_ack;
    endtask

    task automatic advance();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int r;
        n_vec = 0; n_err = 0; m_rmw = 0; m_wait = 0;
        m_rmw_addr = 0; m_rmw_word = 0; last_stall = 0; last_ack = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = pat(i);
        Reset = 1; mem_init = 1;
        set_cpu(1, 1, 32'h0, 32'hFFFF_FFFF, 4'hF);
        set_dma(1, 1, 32'h4, 32'h1111_1111);
        advance();
        sample(); advance();
        sample(); advance();
        Reset = 0; mem_init = 0;

        // Full store then load of the same word
        set_dma(0, 0, 0, 0);
        set_cpu(1, 1, 32'h10, 32'h1234_5678, 4'b1111);
        sample(); chk("fw_write", 32'(MemWrite), 32'd1); chk("fw_nostall", 32'(CpuStall), 32'd0); advance();
        set_cpu(1, 0, 32'h10, 32'h0, 4'b1111);
        sample(); chk("ld_data", CpuRData, 32'h1234_5678); advance();

        // Byte store into lane 1
        set_cpu(1, 1, 32'h10, 32'h0000_AB00, 4'b0010);
        sample(); chk("pw1_stall", 32'(CpuStall), 32'd1); chk("pw1_nowrite", 32'(MemWrite), 32'd0); advance();
        sample(); chk("pw2_write", 32'(MemWrite), 32'd1); chk("pw2_data", MemWData, 32'h1234_AB78);
        chk("pw2_nostall", 32'(CpuStall), 32'd0); advance();
        set_cpu(1, 0, 32'h12, 32'h0, 4'b1111);
        sample(); chk("pw_reload", CpuRData, 32'h1234_AB78); advance();

        // DMA alone: write then read back
        set_cpu(0, 0, 0, 0, 4'h0);
        set_dma(1, 1, 32'h20, 32'hCAFE_F00D);
        sample(); chk("dma_wr_ack", 32'(DmaAck), 32'd1); advance();
        set_dma(1, 0, 32'h20, 32'h0);
        sample(); chk("dma_rd_ack", 32'(DmaAck), 32'd1); chk("dma_rd_data", DmaRData, 32'hCAFE_F00D); advance();

        // Continuous contention: period-5 forced DMA grant
        set_dma(1, 0, 32'h24, 32'h0);
        set_cpu(1, 0, 32'h10, 32'h0, 4'hF);
        for (int k = 0; k < 15; k++) begin
            sample();
            chk("starve_ack", 32'(DmaAck), 32'((k % 5) == 4));
            chk("starve_stall", 32'(CpuStall), 32'((k % 5) == 4));
            advance();
        end
        set_cpu(0, 0, 0, 0, 4'h0); set_dma(0, 0, 0, 0);
        sample(); advance();

        // DMA arriving with a partial store waits out the RMW cycle
        set_cpu(1, 1, 32'h18, 32'h00CD_0000, 4'b0100);
        set_dma(1, 0, 32'h10, 32'h0);
        sample(); chk("pd1_ack", 32'(DmaAck), 32'd0); chk("pd1_stall", 32'(CpuStall), 32'd1); advance();
        sample(); chk("pd2_ack", 32'(DmaAck), 32'd0); chk("pd2_write", 32'(MemWrite), 32'd1); advance();
        set_cpu(0, 0, 0, 0, 4'h0);
        sample(); chk("pd3_ack", 32'(DmaAck), 32'd1); chk("pd3_data", DmaRData, 32'h1234_AB78); advance();
        set_dma(0, 0, 0, 0);

        // Reset during the RMW cycle drops the write
        set_cpu(1, 1, 32'h10, 32'h0000_00EE, 4'b0001);
        sample(); advance();
        Reset = 1;
        sample(); chk("rst_rmw_nowrite", 32'(MemWrite), 32'd0); advance();
        Reset = 0;
        set_cpu(1, 0, 32'h10, 32'h0, 4'hF);
        sample(); chk("rst_rmw_word", CpuRData, 32'h1234_AB78); chk("rst_rmw_idle", 32'(CpuStall), 32'd0); advance();

        // Random traffic honouring the hold rules of both requesters
        for (int c = 0; c < 400; c++) begin
            Reset = ($urandom_range(0, 79) == 0);
            if (!(last_stall || m_rmw)) begin
                r = int'($urandom_range(0, 7));
                set_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        32'($urandom_range(0, 63)), $urandom,
                        (r < 3) ? 4'hF : 4'($urandom_range(0, 15)));
            end
            if (!DmaReq || last_ack) begin
                set_dma($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                        32'($urandom_range(0, 63)), $urandom);
            end
            sample();
            advance();
        end

        Reset = 0;
        set_cpu(0, 0, 0, 0, 4'h0); set_dma(0, 0, 0, 0);
        sample(); advance();
        for (int i = 0; i < 16; i++) chk("mem_final", dm_mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
